// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event controller.
//   evt_type_e  : event codes carried on the event stream
//   btn_state_e : per-channel debounce/classification states
//   slot_t      : one pending-event slot (valid + type)
//   ms_cycles() : clock cycles per millisecond tick for a given clock frequency
package btn_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    typedef struct packed {
        logic      vld;
        evt_type_e typ;
    } slot_t;

    // Cycles per ms; clamps to 1 so very slow clocks still tick every cycle.
    function automatic int unsigned ms_cycles(input int unsigned clk_freq);
        return (clk_freq < 32'd1000) ? 32'd1 : clk_freq / 32'd1000;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchronizer, debounce/classification FSM with a
// saturating ms counter, and a registered one-cycle event post strobe.
// Long-press detection is compiled in only when BTN_EVT_LONG_PRESS_EN is defined.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   btn_i         : raw switch input (1 = pressed)
//   ms_tick_i     : shared 1 ms time-base pulse
//   level_o       : debounced level
//   post_o        : one-cycle event strobe
//   post_type_o   : type of the posted event (valid with post_o)
module btn_channel
    import btn_evt_pkg::*;
#(
    parameter int unsigned StableMs = 10,
    parameter int unsigned LongMs   = 1000
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      btn_i,
    input  logic      ms_tick_i,
    output logic      level_o,
    output logic      post_o,
    output evt_type_e post_type_o
);

`ifdef BTN_EVT_LONG_PRESS_EN
    localparam int unsigned CntTop = LongMs;
`else
    // LongMs has no effect without long-press detection.
    localparam int unsigned CntTop = StableMs + 0 * LongMs;
`endif
    localparam int unsigned CntW = $clog2(CntTop + 1);

    logic            sync1_q;
    logic            sync_q;
    btn_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc_c;
    logic            level_q, level_d;
    logic            post_q, post_d;
    evt_type_e       post_type_q, post_type_d;
`ifdef BTN_EVT_LONG_PRESS_EN
    logic            long_seen_q, long_seen_d;
`endif

    // Counter advances on ms ticks and saturates at its top value.
    assign cnt_inc_c = (ms_tick_i && (cnt_q != CntW'(CntTop))) ? cnt_q + CntW'(1) : cnt_q;

    // Next-state and event logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        post_d      = 1'b0;
        post_type_d = post_type_q;
`ifdef BTN_EVT_LONG_PRESS_EN
        long_seen_d = long_seen_q;
`endif
        case (state_q)
            ST_RELEASED: begin
                if (sync_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(StableMs)) begin
                    state_d     = ST_HELD;
                    level_d     = 1'b1;
                    post_d      = 1'b1;
                    post_type_d = EVT_PRESS;
                    cnt_d       = '0;
`ifdef BTN_EVT_LONG_PRESS_EN
                    long_seen_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            ST_HELD: begin
                if (!sync_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef BTN_EVT_LONG_PRESS_EN
                else begin
                    cnt_d = cnt_inc_c;
                    // LONG goes out once per press, even across release glitches.
                    if ((cnt_q == CntW'(LongMs)) && !long_seen_q) begin
                        long_seen_d = 1'b1;
                        post_d      = 1'b1;
                        post_type_d = EVT_LONG;
                    end
                end
`endif
            end
            ST_RELEASE_WAIT: begin
                if (sync_q) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(StableMs)) begin
                    state_d     = ST_RELEASED;
                    level_d     = 1'b0;
                    post_d      = 1'b1;
                    post_type_d = EVT_RELEASE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Synchronizer and state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b0;
            sync_q      <= 1'b0;
            state_q     <= ST_RELEASED;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            post_q      <= 1'b0;
            post_type_q <= EVT_PRESS;
`ifdef BTN_EVT_LONG_PRESS_EN
            long_seen_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= btn_i;
            sync_q      <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            post_q      <= post_d;
            post_type_q <= post_type_d;
`ifdef BTN_EVT_LONG_PRESS_EN
            long_seen_q <= long_seen_d;
`endif
        end
    end

    assign level_o     = level_q;
    assign post_o      = post_q;
    assign post_type_o = post_type_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// Multi-button front end: debounces NumBtn switches on a shared ms time base,
// classifies PRESS / RELEASE / LONG, buffers one pending event per channel and
// arbitrates them round-robin onto a single valid/ready event stream.
// Optional long-press detection: define BTN_EVT_LONG_PRESS_EN.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   btn_i        : raw switch inputs, 1 = pressed
//   level_o      : debounced level per channel
//   evt_valid_o  : event available
//   evt_ready_i  : consumer accepts when high with evt_valid_o
//   evt_id_o     : channel index of the event
//   evt_type_o   : 0 PRESS, 1 RELEASE, 2 LONG
//   drop_o       : one-cycle pulse when a channel's pending event is overwritten
module btn_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int unsigned NumBtn   = 4,
    parameter int unsigned ClkFreq  = 100_000_000,
    parameter int unsigned StableMs = 10,
    parameter int unsigned LongMs   = 1000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumBtn-1:0]         btn_i,
    output logic [NumBtn-1:0]         level_o,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic [$clog2(NumBtn)-1:0] evt_id_o,
    output logic [1:0]                evt_type_o,
    output logic [NumBtn-1:0]         drop_o
);

    localparam int unsigned IdW      = $clog2(NumBtn);
    localparam int unsigned MsCycles = ms_cycles(ClkFreq);
    localparam int unsigned PreW     = (MsCycles > 1) ? $clog2(MsCycles) : 1;

    logic [PreW-1:0]   pre_q, pre_d;
    logic              ms_tick_c;

    logic [NumBtn-1:0] post_c;
    evt_type_e         post_type_c [NumBtn];
    logic [NumBtn-1:0] slot_vld_c;
    evt_type_e         slot_type_c [NumBtn];

    logic [IdW-1:0]    ptr_q, ptr_d;
    logic              found_c;
    logic              load_c;
    logic              grant_c;
    logic [IdW-1:0]    grant_id_c;
    int unsigned       scan_idx_c;

    logic              evt_valid_q, evt_valid_d;
    logic [IdW-1:0]    evt_id_q, evt_id_d;
    evt_type_e         evt_type_q, evt_type_d;

    // Shared ms prescaler: tick on the terminal count.
    assign ms_tick_c = (pre_q == PreW'(MsCycles - 1));

    always_comb begin
        pre_d = ms_tick_c ? '0 : pre_q + PreW'(1);
    end

    // Per-channel debounce plus its pending slot.
    for (genvar g = 0; g < NumBtn; g++) begin : g_chan
        slot_t slot_q, slot_d;
        logic  drop_q, drop_d;
        logic  granted_c;

        btn_channel #(
            .StableMs (StableMs),
            .LongMs   (LongMs)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .btn_i       (btn_i[g]),
            .ms_tick_i   (ms_tick_c),
            .level_o     (level_o[g]),
            .post_o      (post_c[g]),
            .post_type_o (post_type_c[g])
        );

        assign granted_c = grant_c && (grant_id_c == IdW'(g));

        // A post wins over a same-cycle grant; it only drops when the slot stays occupied.
        always_comb begin
            slot_d = slot_q;
            drop_d = 1'b0;
            if (granted_c) begin
                slot_d.vld = 1'b0;
            end
            if (post_c[g]) begin
                drop_d     = slot_q.vld & ~granted_c;
                slot_d.vld = 1'b1;
                slot_d.typ = post_type_c[g];
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                slot_q <= '0;
                drop_q <= 1'b0;
            end else begin
                slot_q <= slot_d;
                drop_q <= drop_d;
            end
        end

        assign slot_vld_c[g]  = slot_q.vld;
        assign slot_type_c[g] = slot_q.typ;
        assign drop_o[g]      = drop_q;
    end

    // Round-robin scan: first pending slot at or after ptr, wrapping.
    always_comb begin
        found_c    = 1'b0;
        grant_id_c = '0;
        scan_idx_c = 0;
        for (int unsigned i = 0; i < NumBtn; i++) begin
            scan_idx_c = 32'(ptr_q) + i;
            if (scan_idx_c >= NumBtn) begin
                scan_idx_c = scan_idx_c - NumBtn;
            end
            if (!found_c && slot_vld_c[IdW'(scan_idx_c)]) begin
                found_c    = 1'b1;
                grant_id_c = IdW'(scan_idx_c);
            end
        end
    end

    // Output register reloads when empty or being accepted this cycle.
    assign load_c  = !evt_valid_q || evt_ready_i;
    assign grant_c = found_c && load_c;

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_type_d  = evt_type_q;
        ptr_d       = ptr_q;
        if (load_c) begin
            evt_valid_d = found_c;
            if (found_c) begin
                evt_id_d   = grant_id_c;
                evt_type_d = slot_type_c[grant_id_c];
                ptr_d      = (grant_id_c == IdW'(NumBtn - 1)) ? '0 : grant_id_c + IdW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q       <= '0;
            ptr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_type_q  <= EVT_PRESS;
        end else begin
            pre_q       <= pre_d;
            ptr_q       <= ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_type_q  <= evt_type_d;
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_id_o    = evt_id_q;
    assign evt_type_o  = evt_type_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: 10 cycles per ms, StableMs=3, LongMs=20, 4 channels.
// Accepted events are logged by a negedge monitor; each test inspects the log past its own base index.
module tb_btn_event_ctrl;

    localparam int NB = 4;
    localparam logic [1:0] T_PRESS = 2'd0;
    localparam logic [1:0] T_REL   = 2'd1;
    localparam logic [1:0] T_LONG  = 2'd2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] level;
    logic          evt_valid;
    logic          evt_ready = 1'b1;
    logic [1:0]    evt_id;
    logic [1:0]    evt_type;
    logic [NB-1:0] drop;

    int errors = 0;
    int checks = 0;

    logic [3:0] ev_q[$];
    int         ev_cyc_q[$];
    int         drop_cnt [NB];
    int         cyc = 0;

    btn_event_ctrl #(
        .NumBtn   (NB),
        .ClkFreq  (10_000),
        .StableMs (3),
        .LongMs   (20)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_i       (btn),
        .level_o     (level),
        .evt_valid_o (evt_valid),
        .evt_ready_i (evt_ready),
        .evt_id_o    (evt_id),
        .evt_type_o  (evt_type),
        .drop_o      (drop)
    );

    always #5 clk = ~clk;

    // Monitor: log transfers that will complete at the next posedge, count drop cycles.
    initial begin
        for (int i = 0; i < NB; i++) drop_cnt[i] = 0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (!rst && evt_valid && evt_ready) begin
                ev_q.push_back({evt_id, evt_type});
                ev_cyc_q.push_back(cyc);
            end
            for (int i = 0; i < NB; i++) if (drop[i]) drop_cnt[i] = drop_cnt[i] + 1;
        end
    end

    function automatic logic [3:0] mk(input logic [1:0] id, input logic [1:0] typ);
        return {id, typ};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input int ch, input logic val, input int max_cyc,
                              output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (lat < max_cyc && !ok) begin
            step(1);
            lat++;
            if (level[ch] === val) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; btn = '0; evt_ready = 1'b1;
        step(3);
        checks++; if (level !== 4'h0)    begin errors++; $display("FAIL reset_level got=%h exp=0", level); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
        checks++; if (evt_id !== 2'd0)    begin errors++; $display("FAIL reset_id got=%0d exp=0", evt_id); end
        checks++; if (evt_type !== 2'd0)  begin errors++; $display("FAIL reset_type got=%0d exp=0", evt_type); end
        checks++; if (drop !== 4'h0)      begin errors++; $display("FAIL reset_drop got=%h exp=0", drop); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_press_release;
        int base, lat; bit ok;
        base = ev_q.size();
        btn[1] = 1'b1;
        wait_level(1, 1'b1, 60, lat, ok);
        checks++; if (!ok || lat < 21 || lat > 34) begin errors++; $display("FAIL press_latency got=%0d ok=%0b exp=21..34", lat, ok); end
        step(70);
        checks++; if (ev_q.size() - base !== 1) begin errors++; $display("FAIL press_count got=%0d exp=1", ev_q.size() - base); end
        checks++; if (ev_q.size() <= base || ev_q[base] !== mk(2'd1, T_PRESS)) begin errors++; $display("FAIL press_event got=%h exp=%h", (ev_q.size() > base) ? ev_q[base] : 4'hx, mk(2'd1, T_PRESS)); end
        btn[1] = 1'b0;
        wait_level(1, 1'b0, 60, lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL release_level got=%b exp=0", level[1]); end
        step(70);
        checks++; if (ev_q.size() - base !== 2) begin errors++; $display("FAIL release_count got=%0d exp=2", ev_q.size() - base); end
        checks++; if (ev_q.size() <= base + 1 || ev_q[base+1] !== mk(2'd1, T_REL)) begin errors++; $display("FAIL release_event got=%h exp=%h", (ev_q.size() > base + 1) ? ev_q[base+1] : 4'hx, mk(2'd1, T_REL)); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", evt_valid); end
    endtask

    task automatic test_bounce;
        int base; bit rose;
        base = ev_q.size();
        rose = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k % 7 == 0) btn[0] = ~btn[0];
            step(1);
            if (level[0] !== 1'b0) rose = 1'b1;
        end
        btn[0] = 1'b0;
        step(40);
        checks++; if (rose || level[0] !== 1'b0) begin errors++; $display("FAIL bounce_level got_rose=%0b exp=0", rose); end
        checks++; if (ev_q.size() - base !== 0) begin errors++; $display("FAIL bounce_events got=%0d exp=0", ev_q.size() - base); end
        btn[0] = 1'b1;
        step(60);
        checks++; if (ev_q.size() - base !== 1 || ev_q[base] !== mk(2'd0, T_PRESS)) begin errors++; $display("FAIL bounce_then_press count=%0d exp=1 event PRESS id0", ev_q.size() - base); end
        btn[0] = 1'b0;
        step(60);
    endtask

    task automatic test_long;
        int base, lat, exp_n; bit ok, dipped;
`ifdef BTN_EVT_LONG_PRESS_EN
        exp_n = 2;
`else
        exp_n = 1;
`endif
        base = ev_q.size();
        btn[2] = 1'b1;
        wait_level(2, 1'b1, 60, lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL long_press_level got=%b exp=1", level[2]); end
        step(260);
        checks++; if (ev_q.size() - base !== exp_n) begin errors++; $display("FAIL long_count got=%0d exp=%0d", ev_q.size() - base, exp_n); end
        checks++; if (ev_q.size() <= base || ev_q[base] !== mk(2'd2, T_PRESS)) begin errors++; $display("FAIL long_first_press exp=%h", mk(2'd2, T_PRESS)); end
`ifdef BTN_EVT_LONG_PRESS_EN
        checks++; if (ev_q.size() <= base + 1 || ev_q[base+1] !== mk(2'd2, T_LONG)) begin errors++; $display("FAIL long_event exp=%h", mk(2'd2, T_LONG)); end
`endif
        // 1 ms glitch low, then hold past another LongMs
        dipped = 1'b0;
        btn[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin step(1); if (level[2] !== 1'b1) dipped = 1'b1; end
        btn[2] = 1'b1;
        for (int k = 0; k < 250; k++) begin step(1); if (level[2] !== 1'b1) dipped = 1'b1; end
        checks++; if (dipped) begin errors++; $display("FAIL glitch_level got_dip=1 exp=0"); end
        checks++; if (ev_q.size() - base !== exp_n) begin errors++; $display("FAIL glitch_events got=%0d exp=%0d", ev_q.size() - base, exp_n); end
        btn[2] = 1'b0;
        step(60);
        checks++; if (ev_q.size() - base !== exp_n + 1 || ev_q[base+exp_n] !== mk(2'd2, T_REL)) begin errors++; $display("FAIL long_release count=%0d exp=%0d", ev_q.size() - base, exp_n + 1); end
    endtask

    task automatic test_back_to_back;
        int base; bit unstable, bad;
        rst = 1'b1; step(2); rst = 1'b0; step(2);
        evt_ready = 1'b0;
        base = ev_q.size();
        btn = 4'hF;
        step(50);
        checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_type !== T_PRESS) begin errors++; $display("FAIL stall_head got v=%b id=%0d t=%0d exp v=1 id=0 t=0", evt_valid, evt_id, evt_type); end
        unstable = 1'b0;
        for (int k = 0; k < 10; k++) begin step(1); if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_type !== T_PRESS) unstable = 1'b1; end
        checks++; if (unstable) begin errors++; $display("FAIL stall_stable got_unstable=1 exp=0"); end
        evt_ready = 1'b1;
        step(6);
        checks++; if (ev_q.size() - base !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", ev_q.size() - base); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (ev_q.size() <= base + k || ev_q[base+k] !== mk(2'(k), T_PRESS)) begin errors++; $display("FAIL b2b_order idx=%0d exp=%h", k, mk(2'(k), T_PRESS)); end
        end
        checks++; if (ev_q.size() < base + 4 || ev_cyc_q[base+3] - ev_cyc_q[base] !== 3) begin errors++; $display("FAIL b2b_rate got_span=%0d exp=3", (ev_q.size() >= base + 4) ? ev_cyc_q[base+3] - ev_cyc_q[base] : -1); end
        btn = 4'h0;
        step(60);
        bad = (ev_q.size() - base !== 8);
        for (int k = 0; k < 4; k++) if (!bad && ev_q[base+4+k] !== mk(2'(k), T_REL)) bad = 1'b1;
        checks++; if (bad) begin errors++; $display("FAIL b2b_releases count=%0d exp=8 ids 0..3 RELEASE", ev_q.size() - base); end
    endtask

    task automatic test_drop;
        int base, d3, doth;
        evt_ready = 1'b0;
        base = ev_q.size();
        d3   = drop_cnt[3];
        doth = drop_cnt[0] + drop_cnt[1] + drop_cnt[2];
        btn[0] = 1'b1;
        step(45);
        btn[3] = 1'b1;
        step(60);
        btn[3] = 1'b0;
        step(60);
        checks++; if (drop_cnt[3] - d3 !== 1) begin errors++; $display("FAIL drop3_pulses got=%0d exp=1", drop_cnt[3] - d3); end
        checks++; if (drop_cnt[0] + drop_cnt[1] + drop_cnt[2] - doth !== 0) begin errors++; $display("FAIL drop_other got=%0d exp=0", drop_cnt[0] + drop_cnt[1] + drop_cnt[2] - doth); end
        checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin errors++; $display("FAIL drop_head got v=%b id=%0d exp v=1 id=0", evt_valid, evt_id); end
        evt_ready = 1'b1;
        step(5);
        checks++; if (ev_q.size() - base !== 2 || ev_q[base] !== mk(2'd0, T_PRESS) || ev_q[base+1] !== mk(2'd3, T_REL)) begin errors++; $display("FAIL drop_accepted count=%0d exp=2 (ch0 PRESS, ch3 RELEASE)", ev_q.size() - base); end
        btn[0] = 1'b0;
        step(60);
    endtask

    task automatic test_reset_midop;
        int base, lat; bit ok;
        evt_ready = 1'b0;
        btn = 4'b0011;
        step(45);
        btn[3] = 1'b1;
        step(12);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", evt_valid); end
        rst = 1'b1;
        #2;
        checks++; if (evt_valid !== 1'b0 || level !== 4'h0 || evt_id !== 2'd0 || evt_type !== 2'd0 || drop !== 4'h0) begin errors++; $display("FAIL async_reset got v=%b lvl=%h id=%0d t=%0d drop=%h exp all 0", evt_valid, level, evt_id, evt_type, drop); end
        btn[1:0] = 2'b00;
        step(3);
        base = ev_q.size();
        rst = 1'b0;
        wait_level(3, 1'b1, 60, lat, ok);
        checks++; if (!ok || lat < 21 || lat > 34) begin errors++; $display("FAIL post_reset_latency got=%0d ok=%0b exp=21..34", lat, ok); end
        evt_ready = 1'b1;
        step(10);
        checks++; if (ev_q.size() - base !== 1 || ev_q[base] !== mk(2'd3, T_PRESS)) begin errors++; $display("FAIL post_reset_events count=%0d exp=1 (PRESS id3)", ev_q.size() - base); end
        btn[3] = 1'b0;
        step(60);
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_long();
        test_back_to_back();
        test_drop();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
